// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute sequencer for the 16-bit datapath.
// Drives the datapath control word, the data-memory handshake and flag-based branch resolution.
module control_sequencer #(
    parameter int PC_W        = 8,
    parameter int EXEC_CYCLES = 2,
    parameter int RESET_PC    = 0
) (
    input  logic            CLK,
    input  logic            RESET,
    output logic [PC_W-1:0] inst_addr,
    output logic            inst_req,
    input  logic            inst_ack,
    input  logic [15:0]     inst_data,
    output logic [15:0]     CTRWRD,
    output logic [15:0]     Cin,
    input  logic            V,
    input  logic            C,
    input  logic            N,
    input  logic            Z,
    output logic            dmem_rd,
    output logic            dmem_wr,
    input  logic            dmem_ack,
    output logic            halted
);
    localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [15:0]      ir_q, ir_d;
    logic [3:0]       flags_q, flags_d;   // {V,C,N,Z} of the last completed ALU/ADI op
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]        op;
    logic [2:0]        dr, sa, sb, imm;
    logic signed [5:0] offset;
    logic [15:0]       word;
    logic              is_alu;
    logic              drive_word;

    assign op     = ir_q[15:12];
    assign dr     = ir_q[11:9];
    assign sa     = ir_q[8:6];
    assign sb     = ir_q[5:3];
    assign imm    = ir_q[2:0];
    assign offset = {dr, imm};
    assign is_alu = (op <= 4'h8);

    // Control word layout: {DA,AA,BA,MB,FS,MD,RW}
    always_comb begin
        word = '0;
        if (!op[3]) begin
            word = {dr, sa, sb, 1'b0, 1'b0, op[2:0], 1'b0, 1'b1};
        end else begin
            case (op)
                4'h8:    word = {dr, sa, 3'b000, 1'b1, 4'b0010, 1'b0, 1'b1};
                4'h9:    word = {dr, sa, 3'b000, 1'b0, 4'b0000, 1'b1, 1'b1};
                4'hA:    word = {3'b000, sa, sb, 1'b0, 4'b0000, 1'b0, 1'b0};
                default: word = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_FETCH;
            pc_q    <= PC_W'(RESET_PC);
            ir_q    <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_FETCH: begin
                if (inst_ack) begin
                    ir_d    = inst_data;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                cnt_d   = '0;
                state_d = S_FETCH;
                // pc_q already points past the branch, so offsets are relative to the next instruction
                case (op)
                    4'h9, 4'hA: state_d = S_MEM;
                    4'hB:       if (flags_q[0]) pc_d = pc_q + PC_W'(offset);
                    4'hC:       if (flags_q[1]) pc_d = pc_q + PC_W'(offset);
                    4'hD:       pc_d = pc_q + PC_W'(offset);
                    4'hE:       state_d = S_FETCH;
                    4'hF:       state_d = S_HALT;
                    default:    state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                if (cnt_q == CNT_LAST) begin
                    if (is_alu) flags_d = {V, C, N, Z};
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_MEM: begin
                if (dmem_ack) state_d = (op == 4'h9) ? S_EXEC : S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // RESET gates inst_req so no fetch is requested while reset is held
    assign drive_word = (state_q == S_EXEC) || (state_q == S_MEM);
    assign inst_addr  = pc_q;
    assign inst_req   = RESET && (state_q == S_FETCH);
    assign CTRWRD     = drive_word ? word : 16'h0000;
    assign Cin        = (drive_word && op == 4'h8) ? {13'b0, imm} : 16'h0000;
    assign dmem_rd    = (state_q == S_MEM) && (op == 4'h9);
    assign dmem_wr    = (state_q == S_MEM) && (op == 4'hA);
    assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed and random instructions checked against an
// instruction-level model of PC, latched flags, control word and per-cycle schedule.
module tb_control_sequencer;
    localparam int EC = 2;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [7:0]  inst_addr;
    logic        inst_req;
    logic        inst_ack = 1'b0;
    logic [15:0] inst_data = '0;
    logic [15:0] CTRWRD;
    logic [15:0] Cin;
    logic        V = 1'b0, C = 1'b0, N = 1'b0, Z = 1'b0;
    logic        dmem_rd, dmem_wr;
    logic        dmem_ack = 1'b0;
    logic        halted;

    int tests = 0;
    int fails = 0;
    int m_pc = 0;
    logic [3:0] m_flags = 4'b0000;

    control_sequencer #(.PC_W(8), .EXEC_CYCLES(EC), .RESET_PC(0)) dut (
        .CLK(CLK), .RESET(RESET), .inst_addr(inst_addr), .inst_req(inst_req),
        .inst_ack(inst_ack), .inst_data(inst_data), .CTRWRD(CTRWRD), .Cin(Cin),
        .V(V), .C(C), .N(N), .Z(Z), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
        .dmem_ack(dmem_ack), .halted(halted)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Control word assembled field by field from the instruction-set rules
    function automatic logic [15:0] exp_word(input logic [15:0] ins);
        int op, dr, sa, sb;
        int da, aa, ba, mb, fs, md, rw;
        op = int'(ins[15:12]); dr = int'(ins[11:9]); sa = int'(ins[8:6]); sb = int'(ins[5:3]);
        da = 0; aa = 0; ba = 0; mb = 0; fs = 0; md = 0; rw = 0;
        if (op < 8) begin da = dr; aa = sa; ba = sb; fs = op; rw = 1; end
        else if (op == 8) begin da = dr; aa = sa; mb = 1; fs = 2; rw = 1; end
        else if (op == 9) begin da = dr; aa = sa; md = 1; rw = 1; end
        else if (op == 10) begin aa = sa; ba = sb; end
        return 16'(da * 8192 + aa * 1024 + ba * 128 + mb * 64 + fs * 4 + md * 2 + rw);
    endfunction

    // Runs one instruction; call just after a negedge. abort_at >= 1 resets the DUT mid-instruction.
    task automatic do_instr(input logic [15:0] ins, input logic [3:0] flg, input int iack_dly,
                            input int dack_dly, input int abort_at);
        int op, imm, hold, exp_cycles, c, w, off;
        bit in_win, mem_win, is_mem, taken;
        logic [15:0] wd;
        op = int'(ins[15:12]); imm = int'(ins[2:0]);
        is_mem = (op == 9 || op == 10);
        wd = exp_word(ins);
        if (op <= 8) hold = EC;
        else if (op == 9) hold = dack_dly + 1 + EC;
        else if (op == 10) hold = dack_dly + 1;
        else hold = 0;
        exp_cycles = (op == 15) ? 1 : 1 + hold;
        {V, C, N, Z} = flg;

        w = 0;
        while (!inst_req && w < 50) begin @(negedge CLK); w++; end
        check("fetch_req", 32'(inst_req), 32'd1);
        check("inst_addr", 32'(inst_addr), 32'(m_pc));
        for (int i = 0; i < iack_dly; i++) begin
            inst_ack = 1'b0; inst_data = 16'($urandom);
            @(negedge CLK);
            check("req_hold", 32'(inst_req), 32'd1);
        end
        inst_ack = 1'b1; inst_data = ins;
        @(negedge CLK);
        inst_ack = 1'b0;

        c = 0;
        while (!inst_req && !halted && c < 100) begin
            if (c == abort_at) begin
                check("pre_abort_rd", 32'(dmem_rd), 32'd1);
                #2 RESET = 1'b0;
                #1;
                check("abort_rd", 32'(dmem_rd), 32'd0);
                check("abort_req", 32'(inst_req), 32'd0);
                check("abort_cw", 32'(CTRWRD), 32'd0);
                inst_ack = 1'b0; dmem_ack = 1'b0;
                @(negedge CLK);
                RESET = 1'b1;
                m_pc = 0; m_flags = 4'b0000;
                @(negedge CLK);
                return;
            end
            in_win  = (c >= 1 && c <= hold);
            mem_win = is_mem && c >= 1 && c <= 1 + dack_dly;
            check("ctrwrd", 32'(CTRWRD), in_win ? 32'(wd) : 32'd0);
            check("cin", 32'(Cin), (in_win && op == 8) ? 32'(imm) : 32'd0);
            check("dmem_rd", 32'(dmem_rd), 32'(mem_win && op == 9));
            check("dmem_wr", 32'(dmem_wr), 32'(mem_win && op == 10));
            dmem_ack  = mem_win ? (c == 1 + dack_dly) : ($urandom_range(0, 3) == 0);
            inst_ack  = ($urandom_range(0, 3) == 0);
            inst_data = 16'($urandom);
            @(negedge CLK);
            c++;
        end
        inst_ack = 1'b0; dmem_ack = 1'b0;
        check("cycles", 32'(c), 32'(exp_cycles));
        check("halted", 32'(halted), 32'(op == 15));

        off = int'({ins[11:9], ins[2:0]});
        if (off > 31) off -= 64;
        taken = (op == 11 && m_flags[0]) || (op == 12 && m_flags[1]) || (op == 13);
        m_pc = (m_pc + 1) & 255;
        if (taken) m_pc = (m_pc + off) & 255;
        if (op <= 8) m_flags = flg;
        $display("[TB] ins=%h op=%0d cycles=%0d next_pc=%0d flags=%b", ins, op, c, m_pc, m_flags);
    endtask

    initial begin
        logic [15:0] r;
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_req", 32'(inst_req), 32'd0);
        check("rst_cw", 32'(CTRWRD), 32'd0);
        check("rst_halt", 32'(halted), 32'd0);
        check("rst_rd", 32'(dmem_rd), 32'd0);
        RESET = 1'b1;
        @(negedge CLK);
        check("rel_req", 32'(inst_req), 32'd1);
        check("rel_addr", 32'(inst_addr), 32'd0);
        check("rel_cw", 32'(CTRWRD), 32'd0);
        check("rel_halt", 32'(halted), 32'd0);

        do_instr(16'h1298, 4'b0001, 0, 0, -1);   // ADD, Z latched
        do_instr(16'h8455, 4'b0010, 1, 0, -1);   // ADI, N latched
        do_instr(16'h9210, 4'b1111, 0, 5, -1);   // LD, slow memory, flags not latched
        do_instr(16'h2000, 4'b0001, 0, 0, -1);   // ALU leaving Z=1
        do_instr(16'hBE06, 4'b0000, 0, 0, -1);   // BRZ -2 at 4 -> 3
        do_instr(16'h4111, 4'b0000, 2, 0, -1);   // ALU leaving Z=0
        do_instr(16'hBE06, 4'b0001, 0, 0, -1);   // BRZ not taken despite live Z
        do_instr(16'h7FFF, 4'b0001, 0, 0, -1);   // ALU leaving Z=1
        do_instr(16'hDE00, 4'b0000, 0, 0, -1);   // JMP -8 at 6 -> 255
        do_instr(16'hB001, 4'b0000, 0, 0, -1);   // BRZ +1 at 255 wraps to 1
        do_instr(16'hA0D8, 4'b0000, 0, 2, -1);   // ST
        do_instr(16'hC7C7, 4'b0000, 0, 0, -1);   // BRN with latched N=0
        do_instr(16'hE123, 4'b1111, 0, 0, -1);   // NOP

        for (int i = 0; i < 40; i++) begin
            r = 16'($urandom);
            r[15:12] = 4'($urandom_range(0, 14));
            do_instr(r, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 4), -1);
        end

        do_instr(16'h9A48, 4'b0000, 0, 6, 3);    // LD aborted by reset in MEM
        do_instr(16'hC03F, 4'b0010, 0, 0, -1);   // BRN after reset: flags cleared, not taken
        do_instr(16'hF000, 4'b0000, 0, 0, -1);   // HALT
        for (int i = 0; i < 5; i++) begin
            inst_ack = 1'b1;
            @(negedge CLK);
            check("halt_req", 32'(inst_req), 32'd0);
            check("halt_hold", 32'(halted), 32'd1);
        end
        inst_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
